uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one 8N1 UART transmit line between `NREQ` byte requesters. Arbitration is round-robin. The block generates its own bit-rate enable from `clk50` and does not use a divided clock. It sequences start, data, optional parity and stop bits, and grants the line to one requester per frame. It sits between the internal byte producers (command echo, status reporter, debug dump) and the board `tx` pin.

## Interface
- `CLK_FRE`, 50: system clock frequency in MHz.
- `BAUD_RATE`, 115200: serial bit rate.
- `NREQ`, 4: number of requesters, 2..8.
- `clk50`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  NREQ*8  requester i byte at bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot accept strobe, combinational.
- `grant_id`  out  clog2(NREQ)  index of the requester owning the current or last frame.
- `busy`  out  1  high while a frame is on the line.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- Bit period: `BIT_CYCLES = CLK_FRE*1000000/BAUD_RATE`, integer-truncated (434 at defaults).
- `baud_tick` pulses when the bit counter reaches `BIT_CYCLES-1`. The counter then wraps to 0.
- The bit counter is forced to 0 on every frame start, so frames are never phase-aligned to a free-running divider.
- States:
  - `IDLE`
  - `START`: `tx`=0.
  - `DATA`: 8 bits, LSB first, bit index 0..7.
  - `PARITY`: macro-gated.
  - `STOP`: `tx`=1.
- Every non-IDLE state lasts exactly `BIT_CYCLES` clocks, then advances on `baud_tick`.
- Transitions:
  - DATA moves to STOP after bit 7, or to PARITY if that is enabled.
  - STOP returns to IDLE.
- Arbitration runs only in IDLE.
  - Search order starts at `(last_grant+1) mod NREQ`. The first index with `req_valid` high wins.
  - `req_ready[win]`=1 combinationally in the same cycle. All other ready bits are 0, and all are 0 outside IDLE.
- At the handshake edge (`req_valid[i] & req_ready[i]`):
  - latch the byte into the shift register;
  - `last_grant`/`grant_id` <= i;
  - state <= START; `tx` <= 0; `busy` <= 1.
- A requester may drop `req_valid` before it is granted. It must hold its data stable while valid.
- `busy` falls on the edge that leaves STOP.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `grant_id`=0, `req_ready`=0;
  - state IDLE, bit counter 0;
  - `last_grant`=NREQ-1, so requester 0 has first priority.
- Latency: `tx` falls 1 clock after the handshake edge is sampled, i.e. it is registered on that edge.
- Frame length: 10*`BIT_CYCLES` clocks, or 11*`BIT_CYCLES` with parity.
- Back-to-back frames: IDLE occupies exactly 1 clock between frames. The minimum gap of `tx`=1 beyond the stop bit is 1 clock.
- Simultaneous valids: resolved by the round-robin pointer only. There is no fixed priority after reset.
- Reset mid-frame: `tx` returns to 1 asynchronously. The in-flight byte is dropped and is not re-offered by this block.
- A valid that arrives while busy waits. It is sampled in the first IDLE cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted after DATA;
  - `tx` = XOR of the 8 data bits (even parity);
  - frame is 11 bits.
- Undefined: no PARITY state; 8N1, 10-bit frame.

## Structure
- Shared package `uart_pkg`:
  - state enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - `bit_cycles(CLK_FRE, BAUD_RATE)` constant function;
  - `UART_DATA_W`=8.
- One sub-module: `baud_tick_gen`.
  - Ports: `clk50`, `rst_n`, `restart`, `baud_tick`.
  - Parameterised by `BIT_CYCLES`.
  - Counter width: clog2(`BIT_CYCLES`).
- Arbiter, FSM and shift register stay in `uart_tx_arbiter`.

## Test plan
Bench settings: `CLK_FRE`=50, `BAUD_RATE`=5000000, so `BIT_CYCLES`=10 and a frame is 100 clocks.
- Single byte: req0 valid with data 0xA5.
  - `req_ready[0]` pulses for 1 clock.
  - `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each level lasts 10 clocks; `busy` stays high for 100 clocks.
- Round-robin: all four valid continuously after reset.
  - Grant order is 0,1,2,3,0.
  - `grant_id` matches each frame; there is exactly a 1-clock IDLE between frames.
- Late arrival: req2 asserts valid 37 clocks into a req1 frame.
  - No ready is given to req2 until the first IDLE cycle.
  - req2 is then granted ahead of a re-asserted req1.
- Reset mid-frame: `rst_n` is pulled low at clock 55 of a frame.
  - `tx`=1 and `busy`=0 immediately.
  - After release, req0 wins even though req3 is also valid.
- Withdrawn request: req3 pulses valid for 1 clock while busy.
  - No grant is issued, and the next frame goes to the next valid requester.
- Parity build (`UART_TX_PARITY_EN`): data 0x07.
  - Parity bit 1; frame is 110 clocks; stop bit follows parity.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame state encoding, data width and the
// bit-period helper used to size the baud divider.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Clocks per serial bit, integer-truncated.
  function automatic int bit_cycles(input int clk_fre, input int baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-rate enable generator: one-cycle baud_tick every BIT_CYCLES clocks,
// phase-resettable so each frame starts on a fresh bit period.
module baud_tick_gen #(
  parameter int BIT_CYCLES = 434
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic restart,
  output logic baud_tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign baud_tick = (r_cnt == LAST);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart || baud_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART tx line between NREQ byte producers.
// Define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frame).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int NREQ      = 4
) (
  input  logic                          clk50,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*UART_DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic [$clog2(NREQ)-1:0]       grant_id,
  output logic                          busy,
  output logic                          tx
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FRE, BAUD_RATE);
  localparam int GW         = $clog2(NREQ);

  uart_state_t            r_state;
  uart_state_t            w_state_next;
  logic [GW-1:0]          r_last_grant;
  logic [GW-1:0]          r_grant_id;
  logic [GW-1:0]          w_win;
  logic                   w_any;
  logic                   w_handshake;
  logic                   w_baud_tick;
  logic                   w_tx_next;
  logic                   w_busy_next;
  logic [2:0]             r_bit_idx;
  logic [2:0]             w_bit_sel;
  logic [UART_DATA_W-1:0] r_data;
  logic [UART_DATA_W-1:0] w_bytes [NREQ];
  logic                   r_tx;
  logic                   r_busy;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign w_bytes[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
  end

  baud_tick_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .restart   (w_handshake),
    .baud_tick (w_baud_tick)
  );

  // Search starts one past the last winner; first valid index wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(r_last_grant) + k) % NREQ;
      if (!w_any && req_valid[GW'(idx)]) begin
        w_any = 1'b1;
        w_win = GW'(idx);
      end
    end
  end

  assign w_handshake = (r_state == IDLE) && w_any;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (w_handshake) w_state_next = START;
      START:  if (w_baud_tick) w_state_next = DATA;
      DATA: begin
        if (w_baud_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
      PARITY: if (w_baud_tick) w_state_next = STOP;
      STOP:   if (w_baud_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered from the level of the state being entered.
  always_comb begin
    req_ready   = '0;
    w_bit_sel   = r_bit_idx;
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != IDLE);
    if (rst_n && w_handshake) begin
      req_ready[w_win] = 1'b1;
    end
    if ((r_state == DATA) && w_baud_tick) begin
      w_bit_sel = r_bit_idx + 3'd1;
    end
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[w_bit_sel];
      PARITY:  w_tx_next = ^r_data;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_data       <= '0;
      r_bit_idx    <= '0;
      r_last_grant <= GW'(NREQ - 1);
      r_grant_id   <= '0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      if (w_handshake) begin
        r_data       <= w_bytes[w_win];
        r_bit_idx    <= '0;
        r_last_grant <= w_win;
        r_grant_id   <= w_win;
      end else if ((r_state == DATA) && w_baud_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter at 10 clocks/bit; honours UART_TX_PARITY_EN.
module tb_uart_tx_arbiter;

  localparam int BIT_CYC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk50;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_arbiter #(
    .CLK_FRE   (50),
    .BAUD_RATE (5000000),
    .NREQ      (4)
  ) dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx        (tx)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic p);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk50);
  endtask

  // Checks ready after settling; budget 0 means it must already be asserted.
  task automatic wait_ready(input logic [3:0] oh, input string name, input int budget);
    int n;
    n = 0;
    #1;
    while ((req_ready == 4'b0) && (n < budget)) begin
      @(negedge clk50);
      #1;
      n++;
    end
    check(name, 32'(req_ready), 32'(oh));
  endtask

  task automatic wait_busy_low(input string name);
    int n;
    n = 0;
    while (busy && (n < 200)) begin
      @(negedge clk50);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Monitor: decodes each frame from the line and compares with the queue head.
  initial begin : monitor
    logic        prev_busy;
    logic [10:0] fr;
    exp_t        e;
    logic        aborted;
    logic        bad;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk50);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(grant_id), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("frame_grant", 32'(grant_id), 32'(e.id));
`ifdef UART_TX_PARITY_EN
            fr = {1'b1, e.par, e.data, 1'b0};
`else
            fr = {1'b0, 1'b1, e.data, 1'b0};
`endif
            aborted = 1'b0;
            for (int b = 0; b < NBITS && !aborted; b++) begin
              bad = 1'b0;
              for (int c = 0; c < BIT_CYC && !aborted; c++) begin
                if (b != 0 || c != 0) @(negedge clk50);
                if (!rst_n) aborted = 1'b1;
                else if (tx !== fr[4'(b)] || busy !== 1'b1) bad = 1'b1;
              end
              if (!aborted) check($sformatf("frame_bit%0d_level_err", b), 32'(bad), 32'd0);
            end
            if (!aborted) begin
              @(negedge clk50);
              if (rst_n) check("frame_end_busy", 32'(busy), 32'd0);
              $display("frame grant=%0d data=%02h done", e.id, e.data);
            end else begin
              $display("frame grant=%0d data=%02h aborted by reset", e.id, e.data);
            end
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  logic [3:0] rr_oh [5];
  int         bad_ready;

  initial begin : stimulus
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_data  = 32'h0;
    nclk(3);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant_id), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    @(negedge clk50);
    rst_n = 1'b1;

    // Single byte from req0
    @(negedge clk50);
    push(0, 8'hA5, 1'b0);
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    wait_ready(4'b0001, "t1_ready", 5);
    @(negedge clk50);
    check("t1_ready_pulse", 32'(req_ready), 32'd0);
    check("t1_busy_rise", 32'(busy), 32'd1);
    req_valid = 4'b0;
    wait_busy_low("t1_busy_fall");
    check("t1_idle_tx", 32'(tx), 32'd1);

    // Round-robin with all four valid after reset
    rst_n = 1'b0;
    nclk(2);
    rst_n     = 1'b1;
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    push(0, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(2, 8'h33, 1'b0);
    push(3, 8'h44, 1'b0);
    push(0, 8'h11, 1'b0);
    rr_oh[0] = 4'b0001;
    rr_oh[1] = 4'b0010;
    rr_oh[2] = 4'b0100;
    rr_oh[3] = 4'b1000;
    rr_oh[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_busy_low("t2_busy_fall");
      wait_ready(rr_oh[k], $sformatf("t2_grant%0d", k), (k == 0) ? 5 : 0);
      @(negedge clk50);
      check($sformatf("t2_idle_gap%0d", k), 32'(busy), 32'd1);
      if (k == 4) req_valid = 4'b0;
    end
    wait_busy_low("t2_last_fall");

    // Late arrival of req2 during a req1 frame
    push(1, 8'h5D, 1'b1);
    push(2, 8'h3A, 1'b0);
    push(1, 8'h97, 1'b1);
    req_data[15:8] = 8'h5D;
    req_valid      = 4'b0010;
    wait_ready(4'b0010, "t3_req1", 5);
    @(negedge clk50);
    req_valid = 4'b0;
    nclk(37);
    req_data[23:16] = 8'h3A;
    req_valid[2]    = 1'b1;
    bad_ready = 0;
    for (int c = 37; c < 250; c++) begin
      if (c > 37) @(negedge clk50);
      if (!busy) break;
      if (c == 60) begin
        req_data[15:8] = 8'h97;
        req_valid[1]   = 1'b1;
      end
      #1;
      if (req_ready !== 4'b0) bad_ready++;
    end
    check("t3_ready_while_busy", 32'(bad_ready), 32'd0);
    wait_ready(4'b0100, "t3_req2_first", 0);
    @(negedge clk50);
    req_valid[2] = 1'b0;
    wait_busy_low("t3_busy_fall");
    wait_ready(4'b0010, "t3_req1_after", 0);
    @(negedge clk50);
    req_valid[1] = 1'b0;
    wait_busy_low("t3_busy_fall2");

    // Reset at clock 55 of a req2 frame
    push(2, 8'hE1, 1'b0);
    req_data[23:16] = 8'hE1;
    req_valid       = 4'b0100;
    wait_ready(4'b0100, "t4_req2", 5);
    @(negedge clk50);
    req_valid = 4'b0;
    nclk(55);
    check("t4_tx_low_before", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t4_tx_async", 32'(tx), 32'd1);
    check("t4_busy_async", 32'(busy), 32'd0);
    check("t4_grant_async", 32'(grant_id), 32'd0);
    req_data[7:0]   = 8'h3C;
    req_data[31:24] = 8'hC3;
    req_valid       = 4'b1001;
    #1;
    check("t4_ready_in_reset", 32'(req_ready), 32'd0);
    push(0, 8'h3C, 1'b0);
    push(3, 8'hC3, 1'b0);
    nclk(3);
    rst_n = 1'b1;
    wait_ready(4'b0001, "t4_req0_wins", 0);
    @(negedge clk50);
    req_valid[0] = 1'b0;
    wait_busy_low("t4_busy_fall");
    wait_ready(4'b1000, "t4_req3_next", 0);
    @(negedge clk50);
    req_valid[3] = 1'b0;
    wait_busy_low("t4_busy_fall2");

    // Withdrawn req3 pulse while busy
    push(1, 8'h80, 1'b1);
    push(2, 8'h24, 1'b0);
    push(0, 8'h42, 1'b0);
    req_data[15:8] = 8'h80;
    req_valid      = 4'b0010;
    wait_ready(4'b0010, "t5_req1", 5);
    @(negedge clk50);
    req_valid = 4'b0;
    nclk(20);
    req_data[31:24] = 8'h55;
    req_valid[3]    = 1'b1;
    #1;
    check("t5_withdraw_ready", 32'(req_ready), 32'd0);
    @(negedge clk50);
    req_valid[3] = 1'b0;
    nclk(29);
    req_data[7:0]   = 8'h42;
    req_data[23:16] = 8'h24;
    req_valid       = 4'b0101;
    wait_busy_low("t5_busy_fall");
    wait_ready(4'b0100, "t5_req2_next", 0);
    @(negedge clk50);
    req_valid[2] = 1'b0;
    wait_busy_low("t5_busy_fall2");
    wait_ready(4'b0001, "t5_req0_next", 0);
    @(negedge clk50);
    req_valid[0] = 1'b0;
    wait_busy_low("t5_busy_fall3");

    // Odd-weight byte: parity bit 1 when enabled
    push(0, 8'h07, 1'b1);
    req_data[7:0] = 8'h07;
    req_valid     = 4'b0001;
    wait_ready(4'b0001, "t6_req0", 5);
    @(negedge clk50);
    req_valid = 4'b0;
    wait_busy_low("t6_busy_fall");

    nclk(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
